// File: rtl/instr_mem_bank_if.sv
// Bus bundle for instr_mem_bank: streaming loader handshake and fetch port.
//   master : program loader / fetch stage side (drives requests, data)
//   slave  : instruction memory side (drives ready, results, prog_len)
interface instr_mem_bank_if #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned AW    = 4
);
  // loader
  logic             load_start;
  logic             load_valid;
  logic             load_last;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             load_done;
  logic [AW:0]      prog_len;
  // fetch
  logic             fetch_req;
  logic [AW-1:0]    fetch_addr;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [WIDTH-1:0] opcode;
  logic             fetch_err;

  modport master (
    output load_start, load_valid, load_last, load_data,
    input  load_ready, load_done, prog_len,
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, opcode, fetch_err
  );

  modport slave (
    input  load_start, load_valid, load_last, load_data,
    output load_ready, load_done, prog_len,
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, opcode, fetch_err
  );
endinterface

// File: rtl/instr_mem_bank.sv
// Parametrised instruction memory with a streaming loader and a 1-cycle fetch port.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_mem_bank_if.slave (loader handshake, prog_len, fetch port)
// load_ready / fetch_ready decode the state only; everything else is registered.
module instr_mem_bank #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_mem_bank_if.slave  bus
);

  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    prog_len;
  logic             load_done;
  logic             fetch_valid;
  logic             fetch_err;
  logic [WIDTH-1:0] opcode;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             beat_c;
  logic [PW-1:0]    wr_addr_c;
  logic             load_end_c;
  logic             in_range_c;

  // Beat qualification; a restart redirects the coincident beat to word 0.
  always_comb begin
    beat_c     = (state == LOAD) && bus.load_valid;
    wr_addr_c  = bus.load_start ? '0 : wr_ptr;
    load_end_c = beat_c && (bus.load_last || (wr_addr_c == PW'(DEPTH - 1)));
    in_range_c = {1'b0, bus.fetch_addr} < prog_len;
  end

  // Storage array, intentionally not reset; writes are held off during reset.
  always_ff @(posedge clk) begin
    if (rst_n && beat_c) begin
      mem[wr_addr_c[AW-1:0]] <= bus.load_data;
    end
  end

  // Control FSM with registered pulses and fetch results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      prog_len    <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      opcode      <= '0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      case (state)
        EMPTY: begin
          if (bus.load_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          if (beat_c) begin
            wr_ptr <= wr_addr_c + PW'(1);
          end else if (bus.load_start) begin
            wr_ptr <= '0;
          end
          if (load_end_c) begin
            prog_len  <= wr_addr_c + PW'(1);
            state     <= READY;
            load_done <= 1'b1;
          end
        end
        READY: begin
          // A new load wins over a coincident fetch request.
          if (bus.load_start) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            prog_len <= '0;
          end else if (bus.fetch_req) begin
            fetch_valid <= 1'b1;
            if (in_range_c) begin
              opcode    <= mem[bus.fetch_addr];
              fetch_err <= 1'b0;
            end else begin
              opcode    <= '0;
              fetch_err <= 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.load_ready  = (state == LOAD);
  assign bus.fetch_ready = (state == READY);
  assign bus.load_done   = load_done;
  assign bus.prog_len    = prog_len;
  assign bus.fetch_valid = fetch_valid;
  assign bus.opcode      = opcode;
  assign bus.fetch_err   = fetch_err;

endmodule

// File: tb/tb_instr_mem_bank.sv
// Self-checking bench for instr_mem_bank: directed scenarios plus randomized
// load/fetch traffic against a queue-based reference model.
module tb_instr_mem_bank;

  localparam int unsigned WIDTH = 26;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_mem_bank_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  instr_mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: loaded program as a queue, plus last fetch result.
  logic [WIDTH-1:0] mdl_mem [$];
  logic [WIDTH-1:0] mdl_op;
  logic             mdl_err;
  logic [WIDTH-1:0] ld_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    idle_inputs();
    repeat (cycles) tick();
    rst_n = 1'b1;
    mdl_mem.delete();
    mdl_op  = '0;
    mdl_err = 1'b0;
    check("rst_prog_len",    32'(bus.prog_len),    32'd0);
    check("rst_opcode",      32'(bus.opcode),      32'd0);
    check("rst_fetch_err",   32'(bus.fetch_err),   32'd0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_load_done",   32'(bus.load_done),   32'd0);
    check("rst_load_ready",  32'(bus.load_ready),  32'd0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
  endtask

  // Loads ld_q; use_last marks the final beat, otherwise the load must auto-stop at DEPTH.
  task automatic load_words(input bit gaps, input bit use_last);
    int n;
    n = ld_q.size();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    mdl_mem.delete();
    check("ld_ready_on", 32'(bus.load_ready), 32'd1);
    check("ld_len_zero", 32'(bus.prog_len),   32'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          bus.load_valid = 1'b0;
          tick();
          check("ld_gap_done",  32'(bus.load_done),  32'd0);
          check("ld_gap_ready", 32'(bus.load_ready), 32'd1);
        end
      end
      bus.load_valid = 1'b1;
      bus.load_data  = ld_q[i];
      bus.load_last  = use_last && (i == n - 1);
      tick();
      mdl_mem.push_back(ld_q[i]);
      if (i < n - 1) begin
        check("ld_mid_done", 32'(bus.load_done), 32'd0);
        check("ld_mid_len",  32'(bus.prog_len),  32'd0);
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    check("ld_done_pulse", 32'(bus.load_done),   32'd1);
    check("ld_ready_off",  32'(bus.load_ready),  32'd0);
    check("ld_fetch_rdy",  32'(bus.fetch_ready), 32'd1);
    check("ld_prog_len",   32'(bus.prog_len),    32'(mdl_mem.size()));
    tick();
    check("ld_done_clear", 32'(bus.load_done),   32'd0);
  endtask

  task automatic fetch(input int addr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(addr);
    tick();
    if (addr < mdl_mem.size()) begin
      mdl_op  = mdl_mem[addr];
      mdl_err = 1'b0;
    end else begin
      mdl_op  = '0;
      mdl_err = 1'b1;
    end
    check("fetch_valid", 32'(bus.fetch_valid), 32'd1);
    check("fetch_op",    32'(bus.opcode),      32'(mdl_op));
    check("fetch_err",   32'(bus.fetch_err),   32'(mdl_err));
  endtask

  task automatic fetch_idle();
    bus.fetch_req = 1'b0;
    tick();
    check("idle_valid", 32'(bus.fetch_valid), 32'd0);
    check("idle_op",    32'(bus.opcode),      32'(mdl_op));
    check("idle_err",   32'(bus.fetch_err),   32'(mdl_err));
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset, then fetch requests in EMPTY are ignored.
    do_reset(2);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    repeat (3) begin
      tick();
      check("empty_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("empty_fetch_ready", 32'(bus.fetch_ready), 32'd0);
      check("empty_opcode",      32'(bus.opcode),      32'd0);
      check("empty_prog_len",    32'(bus.prog_len),    32'd0);
    end
    bus.fetch_req = 1'b0;

    // Short load and back-to-back fetches, then out-of-range addresses.
    ld_q = '{26'h0000001, 26'h0000002, 26'h3FFFFFF};
    load_words(1'b0, 1'b1);
    fetch(0);
    fetch(1);
    fetch(2);
    fetch(3);
    fetch(15);
    fetch_idle();

    // Full depth without load_last; an 11th beat must be refused.
    ld_q.delete();
    for (int i = 0; i < DEPTH; i++) ld_q.push_back(WIDTH'(32'h100 + i));
    load_words(1'b0, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 26'h0000BAD;
    tick();
    bus.load_valid = 1'b0;
    check("full_extra_ready", 32'(bus.load_ready), 32'd0);
    check("full_extra_len",   32'(bus.prog_len),   32'd10);
    check("full_extra_done",  32'(bus.load_done),  32'd0);
    fetch(9);
    fetch(0);
    fetch(10);
    fetch_idle();

    // Restart mid-load with a coincident final beat.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 26'h11;
    tick();
    bus.load_data  = 26'h22;
    tick();
    bus.load_start = 1'b1;
    bus.load_data  = 26'hAA;
    bus.load_last  = 1'b1;
    tick();
    idle_inputs();
    mdl_mem.delete();
    mdl_mem.push_back(26'hAA);
    check("restart_done", 32'(bus.load_done), 32'd1);
    check("restart_len",  32'(bus.prog_len),  32'd1);
    fetch(0);
    fetch(1);
    fetch_idle();

    // load_start beats a coincident fetch request.
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    tick();
    idle_inputs();
    mdl_mem.delete();
    check("prio_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("prio_load_ready",  32'(bus.load_ready),  32'd1);
    check("prio_prog_len",    32'(bus.prog_len),    32'd0);
    check("prio_opcode_hold", 32'(bus.opcode),      32'(mdl_op));

    // Reset after 4 beats discards the partial program.
    bus.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.load_data = WIDTH'(32'h200 + i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    mdl_op  = '0;
    mdl_err = 1'b0;
    check("mid_rst_ready", 32'(bus.load_ready), 32'd0);
    check("mid_rst_len",   32'(bus.prog_len),   32'd0);
    check("mid_rst_op",    32'(bus.opcode),     32'd0);
    repeat (3) begin
      tick();
      check("mid_rst_done",  32'(bus.load_done),   32'd0);
      check("mid_rst_fetch", 32'(bus.fetch_ready), 32'd0);
    end

    // Randomized programs and fetch streams.
    for (int it = 0; it < 15; it++) begin
      int n;
      bit last;
      n    = $urandom_range(1, DEPTH);
      last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      ld_q.delete();
      for (int i = 0; i < n; i++) ld_q.push_back(WIDTH'($urandom));
      load_words(1'b1, last);
      for (int f = 0; f < 10; f++) begin
        if ($urandom_range(0, 3) == 0) fetch_idle();
        fetch($urandom_range(0, 15));
      end
      fetch_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_bank.md
# instr_mem_bank

Parametrised instruction memory for the execution engine, succeeding the fixed 10 x 26-bit opcode store. It has two front ends:
- a streaming loader that fills the memory through a valid/ready handshake and tracks program length;
- a fetch port with request/ready handshake, fixed one-cycle read latency and out-of-range error reporting.

It sits between the program loader/testbench and the execution engine's fetch stage.

## Interface
- WIDTH, 26, opcode width in bits
- DEPTH, 10, number of opcode words (2..2**AW)
- AW, 4, address width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- load_start  in  1  begin (or restart) a program load
- load_valid  in  1  load_data beat valid
- load_last  in  1  qualifies a beat as the final word of the program
- load_data  in  WIDTH  opcode word to store
- load_ready  out  1  loader can accept a beat
- load_done  out  1  one-cycle pulse, load complete
- prog_len  out  AW+1  number of valid words in memory
- fetch_req  in  1  fetch request
- fetch_addr  in  AW  word address to fetch
- fetch_ready  out  1  fetch port can accept a request
- fetch_valid  out  1  one-cycle pulse, opcode/fetch_err valid
- opcode  out  WIDTH  fetched opcode
- fetch_err  out  1  fetched address was >= prog_len

## Operation
- State machine: EMPTY, LOAD, READY.
- **EMPTY** (reset state)
  - load_ready=0, fetch_ready=0.
  - fetch_req is ignored: no fetch_valid is produced.
  - load_start -> LOAD, wr_ptr<=0.
- **LOAD**
  - load_ready=1, fetch_ready=0.
  - Write beat: load_valid & load_ready. It writes mem[wr_ptr]<=load_data and increments wr_ptr.
  - A write beat with load_last=1, or a write beat at wr_ptr==DEPTH-1, ends the load:
    - prog_len<=wr_ptr+1
    - state -> READY
    - load_done pulses the following cycle.
  - load_start while in LOAD restarts the load. wr_ptr resets to 0. A coincident beat is written to address 0 and wr_ptr becomes 1.
  - prog_len is held at 0 for the whole load.
- **READY**
  - load_ready=0, fetch_ready=1.
  - Accepted fetch: fetch_req & fetch_ready.
    - If fetch_addr < prog_len: opcode<=mem[fetch_addr], fetch_err<=0.
    - Otherwise: opcode<=0, fetch_err<=1.
  - load_start -> LOAD, wr_ptr<=0, prog_len<=0.
  - load_start has priority over fetch: a coincident fetch_req is not accepted.
- Memory array is not reset. Reading an unwritten word is only possible via prog_len, so it never occurs.
- Address arithmetic: wr_ptr is AW+1 bits and never exceeds DEPTH. Comparison against prog_len is unsigned, AW+1 bits.

## Timing
- Reset values (rst_n=0 at rising edge): state EMPTY, wr_ptr 0, prog_len 0, load_done 0, fetch_valid 0, fetch_err 0, opcode 0.
- Reset takes priority over all inputs, including mid-load. A partially loaded program is discarded (prog_len=0).
- load_ready and fetch_ready are combinational from state only, with no input-to-output paths.
- Fetch latency is 1 cycle.
  - A request accepted at edge N gives fetch_valid=1 with opcode/fetch_err in the cycle after edge N.
  - Back-to-back requests are accepted every cycle: throughput 1 fetch per clock.
- opcode and fetch_err hold their last value when fetch_valid=0.
- A fetch accepted in the cycle before load_start still returns valid data from the old program in the next cycle.
- load_done is high exactly one cycle, coincident with the first cycle of READY.
- Load throughput is one word per clock while load_valid stays high.

## Test plan
- **Reset/idle:** assert rst_n=0 for 2 cycles, release, drive fetch_req=1 addr 0 -> fetch_ready=0, fetch_valid stays 0, prog_len=0, opcode=0.
- **Short load + fetch:**
  - Stimulus: load_start, then beats 26'h0000001, 26'h0000002, 26'h3FFFFFF, with load_last on the third.
  - Load response: load_done pulses once, prog_len=3.
  - Stimulus: fetch addr 0,1,2 back-to-back.
  - Fetch response: fetch_valid on 3 consecutive cycles, opcodes 1, 2, 3FFFFFF, fetch_err=0.
- **Out of range:** after the 3-word load, fetch addr 3 and addr 15 -> fetch_valid=1, opcode=0, fetch_err=1 for both.
- **Full-depth auto-stop:**
  - Stimulus: load 10 beats 26'h100+i with load_last never asserted, then an 11th beat.
  - Response: load_ready drops after beat 10, prog_len=10, and the 11th beat is not accepted.
  - Check: fetch addr 9 -> 26'h109.
- **Restart/reload:**
  - Stimulus: mid-load (2 beats in), assert load_start with a coincident beat 26'hAA and load_last=1.
  - Load response: prog_len=1.
  - Check: fetch addr 0 -> 26'hAA.
  - Stimulus: in READY, assert load_start in the same cycle as fetch_req.
  - Fetch response: no fetch_valid, and state goes to LOAD.
- **Reset mid-load:** pulse rst_n=0 after 4 beats -> state EMPTY, prog_len=0, load_done never pulses, load_ready=0.
